// File: rtl/clock_cfg_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : p1v_clk_pkg
// Description : Shared types and constants for the Propeller clock
//               configuration sequencer: sequencer state encoding, CLK
//               register bit positions and default timing values.
// Revision    : 1.0 - initial release
// ============================================================================
package p1v_clk_pkg;

    // Sequencer states; the encoding is fixed so that localparam views of
    // it in the sequencer stay compatible with older tooling.
    typedef enum logic [2:0] {
        BOOT      = 3'd0,
        IDLE      = 3'd1,
        CRES      = 3'd2,
        HALT      = 3'd3,
        RECONF    = 3'd4,
        WAIT_LOCK = 3'd5,
        SETTLE    = 3'd6
    } seq_state_t;

    // CLK register bit positions
    localparam int CFG_RESET     = 7;
    localparam int CFG_PLLENA    = 6;
    localparam int CFG_OSCENA    = 5;
    localparam int CFG_OSCM_HI   = 4;
    localparam int CFG_OSCM_LO   = 3;
    localparam int CFG_CLKSEL_HI = 2;
    localparam int CFG_CLKSEL_LO = 0;
    localparam int CFG_MODE_W    = 7;

    // Default timing
    localparam int              DEF_SYNC_STAGES   = 2;
    localparam int              DEF_STABLE_CYCLES = 16;
    localparam int              DEF_GATE_CYCLES   = 4;
    localparam int              DEF_SETTLE_CYCLES = 64;
    localparam int              DEF_LOCK_TIMEOUT  = 65535;
    localparam int              DEF_RESET_CYCLES  = 32;
    localparam logic [6:0]      DEF_RESET_CFG     = 7'h00;

    // Larger of two integers, used to size the shared sequencer counter.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_cfg_sequencer_cfg_sync.sv
`default_nettype none
// ============================================================================
// Module      : cfg_sync
// Description : Brings the core CLK register and the PLL lock into the
//               sequencer clock domain, detects software reset requests
//               (rising edge of cfg[7]) and qualifies the clock mode once it
//               has held still long enough.
// Revision    : 1.0 - initial release
// ============================================================================
module cfg_sync
    import p1v_clk_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            cfg,
    input  logic                  pll_locked,
    output logic [CFG_MODE_W-1:0] cfg_s,
    output logic                  cfg_stable,
    output logic                  rst_req,
    output logic                  lock_s
);

    localparam int                c_SW     = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_SW-1:0]   c_STABLE = c_SW'(STABLE_CYCLES);
    localparam logic [c_SW-1:0]   c_ONE    = c_SW'(1);

    logic [7:0]               r_cfg_pipe  [SYNC_STAGES];
    logic [SYNC_STAGES-1:0]   r_lock_pipe;
    logic                     r_rst_prev;
    logic [CFG_MODE_W-1:0]    r_mode_last;
    logic [c_SW-1:0]          r_stab_cnt;
    logic [7:0]               w_cfg_sync;
    logic [CFG_MODE_W-1:0]    w_mode;

    assign w_cfg_sync = r_cfg_pipe[SYNC_STAGES-1];
    assign w_mode     = w_cfg_sync[CFG_MODE_W-1:0];

    // Synchronizer chains for cfg and pll_locked
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_cfg_pipe[i] <= '0;
            end
            r_lock_pipe <= '0;
        end else begin
            r_cfg_pipe[0]  <= cfg;
            r_lock_pipe[0] <= pll_locked;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_cfg_pipe[i]  <= r_cfg_pipe[i-1];
                r_lock_pipe[i] <= r_lock_pipe[i-1];
            end
        end
    end

    // Previous reset bit for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rst_prev <= 1'b0;
        end else begin
            r_rst_prev <= w_cfg_sync[CFG_RESET];
        end
    end

    // Stability filter: a change counts as the first cycle of the new value,
    // so the count equals the number of cycles the current value has held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode_last <= '0;
            r_stab_cnt  <= '0;
        end else begin
            r_mode_last <= w_mode;
            if (w_mode != r_mode_last) begin
                r_stab_cnt <= c_ONE;
            end else if (r_stab_cnt != c_STABLE) begin
                r_stab_cnt <= r_stab_cnt + c_ONE;
            end
        end
    end

    assign cfg_s      = w_mode;
    assign cfg_stable = (r_stab_cnt == c_STABLE) && (w_mode == r_mode_last);
    assign rst_req    = w_cfg_sync[CFG_RESET] & ~r_rst_prev;
    assign lock_s     = r_lock_pipe[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/clock_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : clock_cfg_sequencer
// Description : Turns every CLK register change into a gated clock
//               reconfiguration (gate, reprogram, wait for lock, settle) and
//               turns software reset requests into a timed core reset.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_cfg_sequencer
    import p1v_clk_pkg::*;
#(
    parameter int         SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int         STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int         GATE_CYCLES   = DEF_GATE_CYCLES,
    parameter int         SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int         LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int         RESET_CYCLES  = DEF_RESET_CYCLES,
    parameter logic [6:0] RESET_CFG     = DEF_RESET_CFG
) (
    input  logic       clock_160,
    input  logic       res,
    input  logic [7:0] cfg,
    input  logic       pll_locked,
    input  logic       rcfg_ack,
    output logic       rcfg_req,
    output logic [6:0] rcfg_cfg,
    output logic       cog_clk_en,
    output logic       core_res,
    output logic       busy,
    output logic       lock_err
);

    // One counter serves every timed state, so it is sized for the longest.
    localparam int c_CNT_MAX = max2(max2(GATE_CYCLES, SETTLE_CYCLES),
                                    max2(LOCK_TIMEOUT, RESET_CYCLES));
    localparam int c_CW      = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CW-1:0] c_CNT_SAT     = c_CW'(c_CNT_MAX);
    localparam logic [c_CW-1:0] c_GATE_LAST   = c_CW'(GATE_CYCLES - 1);
    localparam logic [c_CW-1:0] c_SETTLE_LAST = c_CW'(SETTLE_CYCLES - 1);
    localparam logic [c_CW-1:0] c_LOCK_LAST   = c_CW'(LOCK_TIMEOUT - 1);
    localparam logic [c_CW-1:0] c_RES_LAST    = c_CW'(RESET_CYCLES - 1);

    localparam logic [2:0] c_ST_BOOT      = BOOT;
    localparam logic [2:0] c_ST_IDLE      = IDLE;
    localparam logic [2:0] c_ST_CRES      = CRES;
    localparam logic [2:0] c_ST_HALT      = HALT;
    localparam logic [2:0] c_ST_RECONF    = RECONF;
    localparam logic [2:0] c_ST_WAIT_LOCK = WAIT_LOCK;
    localparam logic [2:0] c_ST_SETTLE    = SETTLE;

    logic [2:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_inc;
    logic            r_rst_pend;
    logic            r_seen_low;
    logic            r_from_boot;
    logic [6:0]      r_cur_cfg;
    logic [6:0]      r_rcfg_cfg;
    logic            r_rcfg_req;
    logic            r_cog_clk_en;
    logic            r_core_res;
    logic            r_lock_err;

    logic [6:0]      w_cfg_s;
    logic            w_cfg_stable;
    logic            w_rst_req;
    logic            w_lock_s;
    logic            w_cfg_ok;

    cfg_sync #(
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_cfg_sync (
        .clk        (clock_160),
        .rst        (res),
        .cfg        (cfg),
        .pll_locked (pll_locked),
        .cfg_s      (w_cfg_s),
        .cfg_stable (w_cfg_stable),
        .rst_req    (w_rst_req),
        .lock_s     (w_lock_s)
    );

    // Only a settled mode that differs from the active one starts a sequence;
    // anything that changed mid-sequence is re-evaluated here on return.
    assign w_cfg_ok  = w_cfg_stable && (w_cfg_s != r_cur_cfg);
    assign w_cnt_inc = (r_cnt == c_CNT_SAT) ? r_cnt : r_cnt + c_CW'(1);

    // Sequencer state machine with registered outputs (the clock gate enable
    // and reset must be glitch-free).
    always_ff @(posedge clock_160) begin
        if (res) begin
            r_state      <= c_ST_BOOT;
            r_cnt        <= '0;
            r_rst_pend   <= 1'b0;
            r_seen_low   <= 1'b0;
            r_from_boot  <= 1'b0;
            r_cur_cfg    <= RESET_CFG;
            r_rcfg_cfg   <= RESET_CFG;
            r_rcfg_req   <= 1'b0;
            r_cog_clk_en <= 1'b1;
            r_core_res   <= 1'b1;
            r_lock_err   <= 1'b0;
        end else begin
            r_cnt <= w_cnt_inc;
            case (r_state)
                c_ST_BOOT: begin
                    if (w_lock_s) begin
                        r_state     <= c_ST_SETTLE;
                        r_cnt       <= '0;
                        r_from_boot <= 1'b1;
                    end
                end
                c_ST_IDLE: begin
                    if (r_rst_pend) begin
                        r_state    <= c_ST_CRES;
                        r_cnt      <= '0;
                        r_rst_pend <= 1'b0;
                        r_core_res <= 1'b1;
                    end else if (w_cfg_ok) begin
                        r_state      <= c_ST_HALT;
                        r_cnt        <= '0;
                        r_cog_clk_en <= 1'b0;
                        r_rcfg_cfg   <= w_cfg_s;
                    end
                end
                c_ST_CRES: begin
                    if (r_cnt == c_RES_LAST) begin
                        r_state    <= c_ST_IDLE;
                        r_core_res <= 1'b0;
                    end
                end
                c_ST_HALT: begin
                    if (r_cnt == c_GATE_LAST) begin
                        r_state    <= c_ST_RECONF;
                        r_rcfg_req <= 1'b1;
                    end
                end
                c_ST_RECONF: begin
                    if (rcfg_ack) begin
                        r_state    <= c_ST_WAIT_LOCK;
                        r_cnt      <= '0;
                        r_rcfg_req <= 1'b0;
                        r_seen_low <= 1'b0;
                    end
                end
                c_ST_WAIT_LOCK: begin
                    // A lock still high from before reprogramming is stale.
                    if (!w_lock_s) begin
                        r_seen_low <= 1'b1;
                    end
                    if (w_lock_s && r_seen_low) begin
                        r_state <= c_ST_SETTLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_LOCK_LAST) begin
                        r_state    <= c_ST_SETTLE;
                        r_cnt      <= '0;
                        r_lock_err <= 1'b1;
                    end
                end
                c_ST_SETTLE: begin
                    if (r_cnt == c_SETTLE_LAST) begin
                        r_state      <= c_ST_IDLE;
                        r_cog_clk_en <= 1'b1;
                        r_core_res   <= 1'b0;
                        r_from_boot  <= 1'b0;
                        if (!r_from_boot) begin
                            r_cur_cfg <= r_rcfg_cfg;
                        end
                    end
                end
                default: begin
                    r_state      <= c_ST_BOOT;
                    r_cnt        <= '0;
                    r_rcfg_req   <= 1'b0;
                    r_cog_clk_en <= 1'b1;
                    r_core_res   <= 1'b1;
                end
            endcase
            // Placed last so a request arriving while a pending one is
            // consumed is still remembered.
            if (w_rst_req && (r_state != c_ST_BOOT)) begin
                r_rst_pend <= 1'b1;
            end
        end
    end

    assign rcfg_req   = r_rcfg_req;
    assign rcfg_cfg   = r_rcfg_cfg;
    assign cog_clk_en = r_cog_clk_en;
    assign core_res   = r_core_res;
    assign lock_err   = r_lock_err;
    assign busy       = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_clock_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_cfg_sequencer
// Description : Directed self-checking bench for clock_cfg_sequencer: boot,
//               mode change, glitch filtering, software reset, lock timeout
//               and reset in the middle of a reconfiguration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_cfg_sequencer;
    import p1v_clk_pkg::*;

    logic       clock_160 = 1'b0;
    logic       res;
    logic [7:0] cfg;
    logic       pll_locked;
    logic       rcfg_ack;
    logic       rcfg_req;
    logic [6:0] rcfg_cfg;
    logic       cog_clk_en;
    logic       core_res;
    logic       busy;
    logic       lock_err;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    clock_cfg_sequencer #(
        .LOCK_TIMEOUT (1000)
    ) dut (
        .clock_160  (clock_160),
        .res        (res),
        .cfg        (cfg),
        .pll_locked (pll_locked),
        .rcfg_ack   (rcfg_ack),
        .rcfg_req   (rcfg_req),
        .rcfg_cfg   (rcfg_cfg),
        .cog_clk_en (cog_clk_en),
        .core_res   (core_res),
        .busy       (busy),
        .lock_err   (lock_err)
    );

    always #5 clock_160 = ~clock_160;

    task automatic step(input int n);
        repeat (n) @(posedge clock_160);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_total++;
        assert ((obs >= lo) && (obs <= hi)) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Plays the clock generator for one reconfiguration.
    task automatic run_seq(output logic [6:0] prog, output logic done);
        int n;
        done = 1'b0;
        prog = '0;
        n    = 0;
        while (!rcfg_req && n < 200) begin
            step(1);
            n++;
        end
        if (rcfg_req) begin
            prog       = rcfg_cfg;
            pll_locked = 1'b0;
            step(10);
            rcfg_ack = 1'b1;
            step(1);
            rcfg_ack = 1'b0;
            step(20);
            pll_locked = 1'b1;
            n = 0;
            while (!cog_clk_en && n < 300) begin
                step(1);
                n++;
            end
            done = cog_clk_en;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed no completion expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         n;
        int         hi1;
        int         lo;
        int         hi2;
        int         drops;
        int         bad;
        logic       cog_ok;
        logic       done;
        logic [6:0] prog;

        // ---------------- 1. Boot ----------------
        res = 1'b1; cfg = 8'h00; pll_locked = 1'b0; rcfg_ack = 1'b0;
        step(5);
        check("rst_core_res",   core_res,       1);
        check("rst_cog_clk_en", cog_clk_en,     1);
        check("rst_rcfg_req",   rcfg_req,       0);
        check("rst_busy",       busy,           1);
        check("rst_lock_err",   lock_err,       0);
        check("rst_rcfg_cfg",   rcfg_cfg,       7'h00);
        check("rst_state",      dut.r_state,    BOOT);
        res = 1'b0;
        step(20);
        check("boot_core_res_before_lock", core_res, 1);
        pll_locked = 1'b1;
        n = 0; cog_ok = 1'b1;
        while (core_res && n < 300) begin
            step(1);
            n++;
            if (!cog_clk_en) cog_ok = 1'b0;
        end
        check_range("boot_core_res_len", n, 65, 67);
        check("boot_cog_always_on", cog_ok,        1);
        check("boot_busy_after",    busy,          0);
        check("boot_cur_cfg",       dut.r_cur_cfg, 7'h00);

        // ---------------- 2. Mode change ----------------
        cfg = 8'h6F;
        n = 0;
        while (cog_clk_en && n < 100) begin step(1); n++; end
        check_range("mode_gate_latency", n, 18, 20);
        n = 0;
        while (!rcfg_req && n < 50) begin step(1); n++; end
        check("mode_req_delay", n,        4);
        check("mode_rcfg_cfg",  rcfg_cfg, 7'h6F);
        pll_locked = 1'b0;
        step(9);
        check("mode_req_held", rcfg_req, 1);
        rcfg_ack = 1'b1;
        step(1);
        rcfg_ack = 1'b0;
        check("mode_req_dropped", rcfg_req,   0);
        check("mode_gate_off",    cog_clk_en, 0);
        step(100);
        check("mode_gate_off_wait", cog_clk_en, 0);
        pll_locked = 1'b1;
        n = 0;
        while (!cog_clk_en && n < 300) begin step(1); n++; end
        check_range("mode_settle_latency", n, 65, 67);
        check("mode_lock_err", lock_err,      0);
        check("mode_cur_cfg",  dut.r_cur_cfg, 7'h6F);
        check("mode_busy",     busy,          0);

        // ---------------- 3. Glitch filter ----------------
        drops = 0;
        for (int i = 0; i < 200; i++) begin
            if ((i % 8) == 0) cfg = (((i / 8) % 2) == 0) ? 8'h00 : 8'h6F;
            step(1);
            if (!cog_clk_en || rcfg_req) drops++;
        end
        check("glitch_no_halt", drops, 0);
        cfg = 8'h6E;
        run_seq(prog, done);
        check("glitch_seq_done", done, 1);
        check("glitch_rcfg_cfg", prog, 7'h6E);
        drops = 0;
        for (int i = 0; i < 80; i++) begin
            step(1);
            if (!cog_clk_en || rcfg_req) drops++;
        end
        check("glitch_single_seq", drops,         0);
        check("glitch_cur_cfg",    dut.r_cur_cfg, 7'h6E);

        // ---------------- 4. Software reset ----------------
        cfg = 8'hEE;
        n = 0;
        while (!core_res && n < 30) begin step(1); n++; end
        check("swres_rise", core_res, 1);
        hi1 = 0; bad = 0;
        while (core_res && hi1 < 100) begin
            hi1++;
            if (hi1 == 3)  cfg = 8'h6E;
            if (hi1 == 10) cfg = 8'hEE;
            if (hi1 == 14) cfg = 8'h6E;
            if (!cog_clk_en) bad++;
            step(1);
        end
        check("swres_pulse1_len", hi1, 32);
        lo = 0;
        while (!core_res && lo < 10) begin step(1); lo++; end
        check("swres_gap_len", lo, 1);
        hi2 = 0;
        while (core_res && hi2 < 100) begin
            hi2++;
            if (!cog_clk_en) bad++;
            step(1);
        end
        check("swres_pulse2_len", hi2, 32);
        step(10);
        check("swres_no_third", core_res, 0);
        check("swres_cog_on",   bad,      0);
        check("swres_busy",     busy,     0);

        // ---------------- 5. Lock timeout ----------------
        cfg = 8'h05;
        n = 0;
        while (!rcfg_req && n < 100) begin step(1); n++; end
        check("tmo_req_seen", rcfg_req, 1);
        pll_locked = 1'b0;
        step(10);
        rcfg_ack = 1'b1;
        step(1);
        rcfg_ack = 1'b0;
        n = 0;
        while (!lock_err && n < 2000) begin step(1); n++; end
        check("tmo_lock_err_time", n, 1000);
        n = 0;
        while (!cog_clk_en && n < 200) begin step(1); n++; end
        check("tmo_seq_done", cog_clk_en,    1);
        check("tmo_cur_cfg",  dut.r_cur_cfg, 7'h05);
        pll_locked = 1'b1;
        step(30);
        check("tmo_lock_err_sticky", lock_err, 1);
        check("tmo_busy",            busy,     0);

        // ---------------- 6. Reset mid-sequence ----------------
        cfg = 8'h12;
        n = 0;
        while (!rcfg_req && n < 100) begin step(1); n++; end
        check("midres_req_seen", rcfg_req, 1);
        pll_locked = 1'b0;
        step(3);
        res = 1'b1;
        step(1);
        res = 1'b0;
        check("midres_rcfg_req",   rcfg_req,    0);
        check("midres_core_res",   core_res,    1);
        check("midres_state",      dut.r_state, BOOT);
        check("midres_lock_err",   lock_err,    0);
        check("midres_cog_on",     cog_clk_en,  1);
        check("midres_rcfg_cfg",   rcfg_cfg,    7'h00);
        rcfg_ack = 1'b1;
        step(1);
        rcfg_ack = 1'b0;
        step(5);
        check("midres_ack_ignored_state", dut.r_state, BOOT);
        check("midres_ack_ignored_req",   rcfg_req,    0);
        pll_locked = 1'b1;
        n = 0;
        while (core_res && n < 200) begin step(1); n++; end
        check("midres_boot_done", core_res,      0);
        check("midres_cur_cfg",   dut.r_cur_cfg, 7'h00);

        if (n_fail != 0) $display("%0d comparisons did not match", n_fail);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
